logic_unit_scheduler: RTL and testbench
=======================================

# logic_unit_scheduler

Round-robin scheduler that shares one W-bit bitwise logic unit (AND, OR, NOT, NAND, NOR, XOR, XNOR) between NREQ requesters. It arbitrates requests, captures the winner's opcode and operands, executes one operation, and returns the result with the requester ID over a valid/ready handshake. It sits between client blocks and the behavioural gate datapath so that only one gate unit is instantiated.

## Interface
- NREQ, 4, number of requesters (>= 2)
- W, 8, operand/result width in bits
- IDW, $clog2(NREQ), requester ID width (derived, not overridable)

- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- req  in  NREQ  per-requester request, level
- op_in  in  3*NREQ  opcode of requester i at [3i+2:3i]
- a_in  in  W*NREQ  operand A of requester i at [W*i+W-1:W*i]
- b_in  in  W*NREQ  operand B of requester i, same packing
- gnt  out  NREQ  one-hot grant, registered, 1-cycle pulse
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_id  out  IDW  ID of requester that owns the result
- res_data  out  W  result
- res_err  out  1  illegal opcode flag, valid with res_valid
- busy  out  1  high in any state other than IDLE

## Operation
- Opcodes: 0 AND, 1 OR, 2 NOT (~A, B ignored), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 illegal. Illegal opcode: res_data = 0, res_err = 1.
- All operations are bitwise over W bits. No carries, no width growth.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if any req bit is high, select the winner by round-robin, pulse gnt[winner], latch op/A/B/ID of the winner, update last_id = winner, go to EXEC. Otherwise stay.
  - EXEC: compute the result from the latched operands. Register res_data, res_err and res_id. Go to RESP.
  - RESP: res_valid = 1. Hold res_data/res_id/res_err stable. On res_valid & res_ready go to IDLE. Otherwise stay.
- Round-robin: search starts at (last_id + 1) mod NREQ and wraps. The first requester found with req high wins.
- Requesters hold req and operands stable until they see gnt. Operands are not sampled after the grant cycle. If a requester keeps req high after gnt, it re-enters the next arbitration and is ranked lowest.
- req is ignored in EXEC and RESP. No queueing.

## Timing
- Reset (rst_n low at a clk edge):
  - State goes to IDLE.
  - gnt = 0, res_valid = 0, res_id = 0, res_data = 0, res_err = 0, busy = 0.
  - last_id = NREQ-1, so requester 0 has first priority.
- Reset mid-operation (EXEC or RESP): the operation is aborted. No res_valid is produced and the result is lost.
- Latency:
  - req high sampled at edge N: gnt pulses during cycle N+1.
  - res_valid is high from cycle N+2.
  - Minimum 3 cycles per operation with res_ready tied high. The next grant is possible at the edge after the handshake.
- gnt is high for exactly one cycle per grant and is never asserted outside the IDLE→EXEC transition.
- busy rises with gnt and falls on the cycle after the res_valid & res_ready handshake.
- Backpressure: res_ready low holds the FSM in RESP indefinitely with outputs stable.
- Simultaneous requests resolve only through the round-robin pointer. Every requester with a continuously held req is granted within NREQ operations.

## Test plan
- Single op: req = 0001, op0 = 0, A0 = 0xF0, B0 = 0x3C, res_ready = 1 → gnt = 0001 one cycle later; res_valid the next cycle with res_data = 0x30, res_id = 0, res_err = 0.
- Full gate sweep on requester 2: A = 0xF0, B = 0x3C, opcodes 0..6 → results 0x30, 0xFC, 0x0F, 0xCF, 0x03, 0xCC, 0x33. For opcode 2, changing B to 0xFF must not change the result.
- Fairness and wrap: after reset, req = 1111 held with a fresh req each time → grant order 0, 1, 2, 3, 0. Then req = 1010 with last_id = 0 → grants 1, 3, 1.
- Backpressure: hold res_ready = 0 for 5 cycles in RESP while req = 0100 → res_valid stays high, outputs stable, no gnt. Raise res_ready → handshake completes, gnt = 0100 follows one cycle after the return to IDLE.
- Illegal opcode: op = 7, A = 0xAA → res_data = 0x00, res_err = 1, res_id correct. The next legal op gives res_err = 0.
- Reset mid-EXEC: drive rst_n low during EXEC → the next cycle shows all outputs 0 and busy = 0, with no res_valid ever produced for the aborted op. After release, req = 1111 grants requester 0 first.

Source files
------------

// File: rtl/logic_unit_scheduler.sv
// logic_unit_scheduler: round-robin arbiter in front of a single shared
// W-bit bitwise logic unit. One operation at a time: grant, execute, respond.
module logic_unit_scheduler #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [3*NREQ-1:0]         op_in,
    input  logic [W*NREQ-1:0]         a_in,
    input  logic [W*NREQ-1:0]         b_in,
    output logic [NREQ-1:0]           gnt,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [$clog2(NREQ)-1:0]   res_id,
    output logic [W-1:0]              res_data,
    output logic                      res_err,
    output logic                      busy
);

    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned OPW = 3;

    localparam logic [OPW-1:0] OP_AND  = 3'd0;
    localparam logic [OPW-1:0] OP_OR   = 3'd1;
    localparam logic [OPW-1:0] OP_NOT  = 3'd2;
    localparam logic [OPW-1:0] OP_NAND = 3'd3;
    localparam logic [OPW-1:0] OP_NOR  = 3'd4;
    localparam logic [OPW-1:0] OP_XOR  = 3'd5;
    localparam logic [OPW-1:0] OP_XNOR = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    // Round-robin pointer: the most recently granted requester
    logic [IDW-1:0]   last_id_q;

    // Operands latched from the winner in the grant cycle
    logic [OPW-1:0]   op_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [IDW-1:0]   id_q;

    // Arbitration result and winner's payload
    logic             win_found_c;
    logic [IDW-1:0]   win_id_c;
    logic [OPW-1:0]   win_op_c;
    logic [W-1:0]     win_a_c;
    logic [W-1:0]     win_b_c;

    // Logic unit output
    logic [W-1:0]     alu_data_c;
    logic             alu_err_c;

    // Next values of the registered outputs and datapath enables
    logic [NREQ-1:0]  gnt_d;
    logic             res_valid_d;
    logic             busy_d;
    logic             load_c;
    logic             capture_c;

    // Round-robin search starting just after the last winner, wrapping
    always_comb begin
        logic [IDW-1:0] idx;
        win_found_c = 1'b0;
        win_id_c    = '0;
        idx         = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = IDW'((32'(last_id_q) + k) % NREQ);
            if (!win_found_c && req[idx]) begin
                win_found_c = 1'b1;
                win_id_c    = idx;
            end
        end
    end

    // Select the winner's opcode and operands out of the packed buses
    always_comb begin
        win_op_c = '0;
        win_a_c  = '0;
        win_b_c  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_id_c == IDW'(i)) begin
                win_op_c = op_in[OPW*i +: OPW];
                win_a_c  = a_in[W*i +: W];
                win_b_c  = b_in[W*i +: W];
            end
        end
    end

    // Shared bitwise logic unit; opcode 7 returns zero with the error flag
    always_comb begin
        alu_data_c = '0;
        alu_err_c  = 1'b0;
        case (op_q)
            OP_AND:  alu_data_c = a_q & b_q;
            OP_OR:   alu_data_c = a_q | b_q;
            OP_NOT:  alu_data_c = ~a_q;
            OP_NAND: alu_data_c = ~(a_q & b_q);
            OP_NOR:  alu_data_c = ~(a_q | b_q);
            OP_XOR:  alu_data_c = a_q ^ b_q;
            OP_XNOR: alu_data_c = ~(a_q ^ b_q);
            default: alu_err_c  = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (win_found_c) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                if (res_valid && res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic: next values for the registered outputs and datapath loads
    always_comb begin
        gnt_d       = '0;
        res_valid_d = 1'b0;
        busy_d      = 1'b0;
        load_c      = 1'b0;
        capture_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_found_c) begin
                    gnt_d  = NREQ'(1) << win_id_c;
                    busy_d = 1'b1;
                    load_c = 1'b1;
                end
            end
            S_EXEC: begin
                capture_c   = 1'b1;
                res_valid_d = 1'b1;
                busy_d      = 1'b1;
            end
            S_RESP: begin
                if (!(res_valid && res_ready)) begin
                    res_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            default: begin
                gnt_d = '0;
            end
        endcase
    end

    // Handshake and grant output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt       <= '0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            gnt       <= gnt_d;
            res_valid <= res_valid_d;
            busy      <= busy_d;
        end
    end

    // Operand latch in the grant cycle, result capture in EXEC
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_id_q <= IDW'(NREQ - 1);
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= '0;
            res_id    <= '0;
            res_data  <= '0;
            res_err   <= 1'b0;
        end else begin
            if (load_c) begin
                last_id_q <= win_id_c;
                op_q      <= win_op_c;
                a_q       <= win_a_c;
                b_q       <= win_b_c;
                id_q      <= win_id_c;
            end
            if (capture_c) begin
                res_id   <= id_q;
                res_data <= alu_data_c;
                res_err  <= alu_err_c;
            end
        end
    end

endmodule

// File: tb/tb_logic_unit_scheduler.sv
// tb_logic_unit_scheduler: directed bench with a result scoreboard.
module tb_logic_unit_scheduler;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 8;
    localparam int unsigned IDW  = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req;
    logic [3*NREQ-1:0]   op_in;
    logic [W*NREQ-1:0]   a_in;
    logic [W*NREQ-1:0]   b_in;
    logic [NREQ-1:0]     gnt;
    logic                res_valid;
    logic                res_ready;
    logic [IDW-1:0]      res_id;
    logic [W-1:0]        res_data;
    logic                res_err;
    logic                busy;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W-1:0]   data;
        logic           err;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    logic [2:0]   op_v [NREQ];
    logic [W-1:0] a_v  [NREQ];
    logic [W-1:0] b_v  [NREQ];

    logic [W-1:0] sweep_exp [7];

    always #5 clk = ~clk;

    // Pack per-requester stimulus onto the DUT buses
    always_comb begin
        op_in = '0;
        a_in  = '0;
        b_in  = '0;
        for (int i = 0; i < NREQ; i++) begin
            op_in[3*i +: 3] = op_v[i];
            a_in[W*i +: W]  = a_v[i];
            b_in[W*i +: W]  = b_v[i];
        end
    end

    logic_unit_scheduler #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .op_in     (op_in),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_data  (res_data),
        .res_err   (res_err),
        .busy      (busy)
    );

    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~a;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return a ^ b;
            3'd6:    return ~(a ^ b);
            default: return '0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b);
        op_v[id] = op;
        a_v[id]  = a;
        b_v[id]  = b;
    endtask

    task automatic randomize_all();
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 3'($urandom_range(6, 0)), W'($urandom), W'($urandom));
        end
    endtask

    // Raise req, wait (bounded) for the grant, check it and queue the expected result
    task automatic issue(input string tag, input logic [NREQ-1:0] mask, input int exp_id,
                         input logic [W-1:0] exp_data, input logic exp_err, input bit push,
                         output int lat);
        exp_t e;
        int   c;
        req = mask;
        lat = 0;
        c   = 0;
        while (lat == 0 && c < 6) begin
            @(posedge clk); #1;
            c++;
            if (gnt !== '0) lat = c;
        end
        check({tag, "_gnt"}, 32'(gnt), 32'(1) << exp_id);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        req = '0;
        if (push) begin
            e.id   = IDW'(exp_id);
            e.data = exp_data;
            e.err  = exp_err;
            sb.push_back(e);
        end
    endtask

    task automatic issue_model(input string tag, input logic [NREQ-1:0] mask, input int exp_id);
        int lat;
        issue(tag, mask, exp_id, model(op_v[exp_id], a_v[exp_id], b_v[exp_id]),
              op_v[exp_id] == 3'd7, 1'b1, lat);
    endtask

    // Wait (bounded) for res_valid, compare with the scoreboard, optionally stall, then handshake
    task automatic wait_result(input string tag, input int stall, output int lat);
        exp_t e;
        int   c;
        res_ready = (stall == 0);
        c = 0;
        while (res_valid !== 1'b1 && c < 8) begin
            @(posedge clk); #1;
            c++;
        end
        lat = c;
        check({tag, "_valid"}, 32'(res_valid), 32'd1);
        check({tag, "_sb"}, 32'(sb.size()), 32'd1);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        check({tag, "_id"}, 32'(res_id), 32'(e.id));
        check({tag, "_data"}, 32'(res_data), 32'(e.data));
        check({tag, "_err"}, 32'(res_err), 32'(e.err));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 32'(res_valid), 32'd1);
            check({tag, "_hold_data"}, 32'(res_data), 32'(e.data));
            check({tag, "_hold_id"}, 32'(res_id), 32'(e.id));
            check({tag, "_hold_gnt"}, 32'(gnt), 32'd0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_done_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_done_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int lat;
        int rlat;
        int exp_order [5];
        int exp_order2 [3];
        string t;

        sweep_exp = '{8'h30, 8'hFC, 8'h0F, 8'hCF, 8'h03, 8'hCC, 8'h33};
        exp_order  = '{0, 1, 2, 3, 0};
        exp_order2 = '{1, 3, 1};

        rst_n     = 1'b0;
        req       = '0;
        res_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 3'd0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_id", 32'(res_id), 32'd0);
        check("rst_data", 32'(res_data), 32'd0);
        check("rst_err", 32'(res_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single AND operation on requester 0
        set_req(0, 3'd0, 8'hF0, 8'h3C);
        issue("single", 4'b0001, 0, 8'h30, 1'b0, 1'b1, lat);
        check("single_gnt_lat", 32'(lat), 32'd1);
        wait_result("single", 0, rlat);
        check("single_res_lat", 32'(rlat), 32'd1);

        // Gate sweep on requester 2
        for (int op = 0; op < 7; op++) begin
            t = $sformatf("sweep%0d", op);
            set_req(2, 3'(op), 8'hF0, 8'h3C);
            issue(t, 4'b0100, 2, sweep_exp[op], 1'b0, 1'b1, lat);
            wait_result(t, 0, rlat);
        end
        set_req(2, 3'd2, 8'hF0, 8'hFF);
        issue("not_bff", 4'b0100, 2, 8'h0F, 1'b0, 1'b1, lat);
        wait_result("not_bff", 0, rlat);

        // Fairness and wrap from reset
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            t = $sformatf("rr%0d", k);
            randomize_all();
            issue_model(t, 4'b1111, exp_order[k]);
            wait_result(t, 0, rlat);
        end
        for (int k = 0; k < 3; k++) begin
            t = $sformatf("rr1010_%0d", k);
            randomize_all();
            issue_model(t, 4'b1010, exp_order2[k]);
            wait_result(t, 0, rlat);
        end

        // Backpressure with requester 2 waiting
        set_req(0, 3'd1, 8'h81, 8'h18);
        set_req(2, 3'd5, 8'h5A, 8'hFF);
        issue_model("bp", 4'b0001, 0);
        req = 4'b0100;
        wait_result("bp", 5, rlat);
        check("bp_idle_gnt", 32'(gnt), 32'd0);
        issue_model("bp_next", 4'b0100, 2);
        check("bp_next_lat", 32'(lat), 32'd1);
        wait_result("bp_next", 0, rlat);

        // Illegal opcode followed by a legal one
        set_req(1, 3'd7, 8'hAA, 8'h55);
        issue("illegal", 4'b0010, 1, 8'h00, 1'b1, 1'b1, lat);
        wait_result("illegal", 0, rlat);
        set_req(1, 3'd5, 8'hAA, 8'h0F);
        issue("legal", 4'b0010, 1, 8'hA5, 1'b0, 1'b1, lat);
        wait_result("legal", 0, rlat);

        // Reset while in EXEC aborts the operation
        set_req(3, 3'd1, 8'h0F, 8'hF0);
        issue("abort", 4'b1000, 3, 8'h00, 1'b0, 1'b0, lat);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_gnt", 32'(gnt), 32'd0);
        check("abort_valid", 32'(res_valid), 32'd0);
        check("abort_id", 32'(res_id), 32'd0);
        check("abort_data", 32'(res_data), 32'd0);
        check("abort_err", 32'(res_err), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("abort_no_valid", 32'(res_valid), 32'd0);
        end
        randomize_all();
        issue_model("post_rst", 4'b1111, 0);
        wait_result("post_rst", 0, rlat);

        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
